reorder_buffer: RTL and testbench
=================================

# reorder_buffer

Circular in-order retirement queue of the out-of-order RV32 core. Allocates one entry per issued instruction, collects results from the common data bus, answers the register file's two operand-forwarding queries, and retires the head entry in program order: register writes to the register file, store release to the load/store buffer, branch-mispredict flush and halt.

## Interface
- ROB_WIDTH_BIT, 3: log2 of entry count; SIZE = 2^ROB_WIDTH_BIT.
- clk_in  in  1  system clock; single clock domain.
- rst_in  in  1  synchronous, active-high reset.
- rdy_in  in  1  ready; low freezes all state and holds all registered outputs.
- issue_valid  in  1  allocate entry at tail this cycle.
- issue_type  in  2  0 REG, 1 STORE, 2 BRANCH, 3 EXIT.
- issue_rd  in  5  destination register; 0 = none.
- issue_pc  in  32  instruction PC.
- issue_pred_jump  in  1  predictor's taken decision.
- issue_jump_addr  in  32  branch target if taken.
- tail_id  out  ROB_WIDTH_BIT  id the next issue receives.
- rob_full  out  1  count == SIZE.
- wb_valid  in  1  CDB result valid.
- wb_rob_id  in  ROB_WIDTH_BIT  producing entry.
- wb_value  in  32  result (rd value; link value for BRANCH).
- wb_jump  in  1  BRANCH actual taken.
- get_rob_id1 / get_rob_id2  in  ROB_WIDTH_BIT  register-file queries.
- rob_value1_ready / rob_value2_ready  out  1  queried entry has result.
- rob_value1 / rob_value2  out  32  queried entry result.
- set_reg_id  out  5  retiring rd; 0 = no write.
- set_val  out  32  retiring value.
- set_reg_on_rob_id  out  ROB_WIDTH_BIT  retiring entry id.
- commit_store  out  1  STORE retired (one-cycle pulse).
- commit_rob_id  out  ROB_WIDTH_BIT  id of retired STORE.
- rob_clear  out  1  mispredict flush pulse.
- clear_pc  out  32  redirect PC, valid with rob_clear.
- halt  out  1  EXIT retired; sticky until reset.

## Operation
- Storage per entry: busy, ready, type, rd, pc, pred_jump, jump_addr, value, jump. Pointers head, tail (ROB_WIDTH_BIT, wrap modulo SIZE), count (ROB_WIDTH_BIT+1 bits).
- Issue: if issue_valid && !rob_full, entry[tail] <= busy=1, ready=(type==EXIT), fields captured; tail++. Issue while rob_full is ignored.
- Writeback: if wb_valid && entry[wb_rob_id].busy, set ready=1, value=wb_value, jump=wb_jump. Writeback to non-busy entry ignored.
- Query (combinational): ready_k = entry[id].ready || (wb_valid && wb_rob_id==id); value_k = bypassed wb_value when matching writeback, else entry value. Ready/value of a retired slot retained until reallocation.
- Commit: when entry[head].busy && ready && !halt, at posedge: busy=0, head++, count--. Registered outputs for the following cycle:
  - REG: set_reg_id=rd, set_val=value, set_reg_on_rob_id=head.
  - STORE: commit_store=1, commit_rob_id=head; set_reg_id=0.
  - BRANCH: set_reg_id=rd (link value). If jump != pred_jump: rob_clear=1, clear_pc = jump ? jump_addr : pc+4.
  - EXIT: halt=1; no further commits.
- Non-commit cycles: set_reg_id=0, commit_store=0, rob_clear=0.
- Flush: in the cycle rob_clear is high, issue_valid and wb_valid are ignored; at that posedge all busy/ready cleared, head=tail=count=0. rob_clear deasserts the following cycle.
- Simultaneous issue and commit: count unchanged; issue to slot freed same cycle is legal only when not full at cycle start.
- Writeback and commit of the same entry in one cycle: no commit; commit occurs next cycle from stored ready.

## Timing
- Reset: all entries non-busy, head=tail=count=0; tail_id=0, rob_full=0, set_reg_id=0, set_val=0, set_reg_on_rob_id=0, commit_store=0, commit_rob_id=0, rob_clear=0, clear_pc=0, halt=0.
- Issue → entry visible to commit logic: 1 cycle. Writeback → commit outputs: earliest 2 cycles (ready stored at edge 1, commit outputs at edge 2).
- Query bypass: zero latency from wb_valid.
- Throughput: one issue, one writeback, one commit per cycle.
- Reset mid-operation overrides everything, including a pending rob_clear.

## Test plan
- Reset, issue REG rd=5 (id 0), wb id0 value 0x1234 → two cycles later set_reg_id=5, set_val=0x1234, set_reg_on_rob_id=0 for one cycle.
- Issue SIZE entries → rob_full=1 after 8th (SIZE=8), 9th issue ignored, tail_id wraps to 0; commit one → rob_full=0.
- Query id 2 while wb_valid id2 value 0xBEEF → rob_value1_ready=1, rob_value1=0xBEEF same cycle; unready id → ready=0.
- BRANCH pc=0x100 pred_jump=1, wb_jump=0, three younger entries → rob_clear pulse, clear_pc=0x104, all entries freed, tail_id=0, younger wbs ignored.
- STORE at head then EXIT → commit_store=1 with commit_rob_id, set_reg_id=0; then halt=1 and stays high.
- Out-of-order wb (id1 before id0) → commits in order 0 then 1; rdy_in low for 3 cycles freezes outputs and pointers.

Source files
------------

// File: rtl/reorder_buffer.sv
// ---------------------------------------------------------------------------
// reorder_buffer
//   Circular in-order retirement queue for the out-of-order RV32 core.
//   Entries are allocated at the tail on issue. Results arrive from the common
//   data bus. Two combinational operand queries serve the register file, and
//   the head entry retires in program order.
//
// Ports
//   clk_in, rst_in, rdy_in        clock, synchronous active-high reset, global
//                                 enable (low freezes all state and outputs)
//   issue_*                       allocation request (type, rd, pc, prediction)
//   tail_id, rob_full             id given to the next issue, queue full flag
//   wb_*                          common-data-bus writeback
//   get_rob_id1/2, rob_value1/2*  operand forwarding queries (combinational)
//   set_reg_id, set_val,
//   set_reg_on_rob_id             registered register-file write of the
//                                 retiring entry
//   commit_store, commit_rob_id   registered store-release pulse
//   rob_clear, clear_pc           registered mispredict flush pulse + redirect
//   halt                          sticky, set when EXIT retires
// ---------------------------------------------------------------------------
module reorder_buffer #(
    parameter int ROB_WIDTH_BIT = 3
) (
    input  logic                     clk_in,
    input  logic                     rst_in,
    input  logic                     rdy_in,
    input  logic                     issue_valid,
    input  logic [1:0]               issue_type,
    input  logic [4:0]               issue_rd,
    input  logic [31:0]              issue_pc,
    input  logic                     issue_pred_jump,
    input  logic [31:0]              issue_jump_addr,
    output logic [ROB_WIDTH_BIT-1:0] tail_id,
    output logic                     rob_full,
    input  logic                     wb_valid,
    input  logic [ROB_WIDTH_BIT-1:0] wb_rob_id,
    input  logic [31:0]              wb_value,
    input  logic                     wb_jump,
    input  logic [ROB_WIDTH_BIT-1:0] get_rob_id1,
    input  logic [ROB_WIDTH_BIT-1:0] get_rob_id2,
    output logic                     rob_value1_ready,
    output logic                     rob_value2_ready,
    output logic [31:0]              rob_value1,
    output logic [31:0]              rob_value2,
    output logic [4:0]               set_reg_id,
    output logic [31:0]              set_val,
    output logic [ROB_WIDTH_BIT-1:0] set_reg_on_rob_id,
    output logic                     commit_store,
    output logic [ROB_WIDTH_BIT-1:0] commit_rob_id,
    output logic                     rob_clear,
    output logic [31:0]              clear_pc,
    output logic                     halt
);

    localparam int SIZE = 1 << ROB_WIDTH_BIT;

    localparam logic [1:0] TYPE_REG    = 2'd0;
    localparam logic [1:0] TYPE_STORE  = 2'd1;
    localparam logic [1:0] TYPE_BRANCH = 2'd2;
    localparam logic [1:0] TYPE_EXIT   = 2'd3;

    localparam logic [ROB_WIDTH_BIT-1:0] ID_ONE     = ROB_WIDTH_BIT'(1);
    localparam logic [ROB_WIDTH_BIT-1:0] ID_ZERO    = ROB_WIDTH_BIT'(0);
    localparam logic [ROB_WIDTH_BIT:0]   COUNT_ONE  = (ROB_WIDTH_BIT+1)'(1);
    localparam logic [ROB_WIDTH_BIT:0]   COUNT_ZERO = (ROB_WIDTH_BIT+1)'(0);
    localparam logic [ROB_WIDTH_BIT:0]   COUNT_FULL = (ROB_WIDTH_BIT+1)'(SIZE);

    // Entry storage
    logic        busy_r      [SIZE];
    logic        ready_r     [SIZE];
    logic [1:0]  type_r      [SIZE];
    logic [4:0]  rd_r        [SIZE];
    logic [31:0] pc_r        [SIZE];
    logic        pred_r      [SIZE];
    logic [31:0] jump_addr_r [SIZE];
    logic [31:0] value_r     [SIZE];
    logic        jump_r      [SIZE];

    logic [ROB_WIDTH_BIT-1:0] head_r;
    logic [ROB_WIDTH_BIT-1:0] tail_r;
    logic [ROB_WIDTH_BIT:0]   count_r;

    // Registered outputs
    logic [4:0]               set_reg_id_r;
    logic [31:0]              set_val_r;
    logic [ROB_WIDTH_BIT-1:0] set_reg_on_rob_id_r;
    logic                     commit_store_r;
    logic [ROB_WIDTH_BIT-1:0] commit_rob_id_r;
    logic                     rob_clear_r;
    logic [31:0]              clear_pc_r;
    logic                     halt_r;

    logic        full_s;
    logic        issue_s;
    logic        wb_s;
    logic        commit_s;
    logic        mispredict_s;
    logic [31:0] redirect_pc_s;

    assign full_s            = (count_r == COUNT_FULL);
    assign tail_id           = tail_r;
    assign rob_full          = full_s;
    assign set_reg_id        = set_reg_id_r;
    assign set_val           = set_val_r;
    assign set_reg_on_rob_id = set_reg_on_rob_id_r;
    assign commit_store      = commit_store_r;
    assign commit_rob_id     = commit_rob_id_r;
    assign rob_clear         = rob_clear_r;
    assign clear_pc          = clear_pc_r;
    assign halt              = halt_r;

    // Per-cycle control decisions. The flush cycle (rob_clear high) blocks
    // issue, writeback and commit so nothing younger than the branch survives.
    always_comb begin
        issue_s       = 1'b0;
        wb_s          = 1'b0;
        commit_s      = 1'b0;
        mispredict_s  = 1'b0;
        redirect_pc_s = 32'd0;
        if (!rob_clear_r) begin
            issue_s  = issue_valid && !full_s;
            wb_s     = wb_valid && busy_r[wb_rob_id];
            commit_s = busy_r[head_r] && ready_r[head_r] && !halt_r;
        end else begin
            issue_s  = 1'b0;
            wb_s     = 1'b0;
            commit_s = 1'b0;
        end
        mispredict_s = (type_r[head_r] == TYPE_BRANCH) && (jump_r[head_r] != pred_r[head_r]);
        if (jump_r[head_r]) begin
            redirect_pc_s = jump_addr_r[head_r];
        end else begin
            redirect_pc_s = pc_r[head_r] + 32'd4;
        end
    end

    // Operand query port 1: a same-cycle writeback to the queried id bypasses storage.
    always_comb begin
        rob_value1_ready = ready_r[get_rob_id1];
        rob_value1       = value_r[get_rob_id1];
        if (wb_valid && (wb_rob_id == get_rob_id1)) begin
            rob_value1_ready = 1'b1;
            rob_value1       = wb_value;
        end else begin
            rob_value1_ready = ready_r[get_rob_id1];
            rob_value1       = value_r[get_rob_id1];
        end
    end

    // Operand query port 2: same bypass rule as port 1.
    always_comb begin
        rob_value2_ready = ready_r[get_rob_id2];
        rob_value2       = value_r[get_rob_id2];
        if (wb_valid && (wb_rob_id == get_rob_id2)) begin
            rob_value2_ready = 1'b1;
            rob_value2       = wb_value;
        end else begin
            rob_value2_ready = ready_r[get_rob_id2];
            rob_value2       = value_r[get_rob_id2];
        end
    end

    // Entry storage, pointers and registered commit outputs.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            for (int i = 0; i < SIZE; i++) begin
                busy_r[i]      <= 1'b0;
                ready_r[i]     <= 1'b0;
                type_r[i]      <= TYPE_REG;
                rd_r[i]        <= 5'd0;
                pc_r[i]        <= 32'd0;
                pred_r[i]      <= 1'b0;
                jump_addr_r[i] <= 32'd0;
                value_r[i]     <= 32'd0;
                jump_r[i]      <= 1'b0;
            end
            head_r              <= ID_ZERO;
            tail_r              <= ID_ZERO;
            count_r             <= COUNT_ZERO;
            set_reg_id_r        <= 5'd0;
            set_val_r           <= 32'd0;
            set_reg_on_rob_id_r <= ID_ZERO;
            commit_store_r      <= 1'b0;
            commit_rob_id_r     <= ID_ZERO;
            rob_clear_r         <= 1'b0;
            clear_pc_r          <= 32'd0;
            halt_r              <= 1'b0;
        end else if (rdy_in) begin
            set_reg_id_r   <= 5'd0;
            commit_store_r <= 1'b0;
            rob_clear_r    <= 1'b0;
            if (rob_clear_r) begin
                for (int i = 0; i < SIZE; i++) begin
                    busy_r[i]  <= 1'b0;
                    ready_r[i] <= 1'b0;
                end
                head_r  <= ID_ZERO;
                tail_r  <= ID_ZERO;
                count_r <= COUNT_ZERO;
            end else begin
                if (wb_s) begin
                    ready_r[wb_rob_id] <= 1'b1;
                    value_r[wb_rob_id] <= wb_value;
                    jump_r[wb_rob_id]  <= wb_jump;
                end
                if (commit_s) begin
                    busy_r[head_r] <= 1'b0;
                    head_r         <= head_r + ID_ONE;
                    case (type_r[head_r])
                        TYPE_REG: begin
                            set_reg_id_r        <= rd_r[head_r];
                            set_val_r           <= value_r[head_r];
                            set_reg_on_rob_id_r <= head_r;
                        end
                        TYPE_STORE: begin
                            commit_store_r  <= 1'b1;
                            commit_rob_id_r <= head_r;
                        end
                        TYPE_BRANCH: begin
                            set_reg_id_r        <= rd_r[head_r];
                            set_val_r           <= value_r[head_r];
                            set_reg_on_rob_id_r <= head_r;
                            if (mispredict_s) begin
                                rob_clear_r <= 1'b1;
                                clear_pc_r  <= redirect_pc_s;
                            end
                        end
                        TYPE_EXIT: begin
                            halt_r <= 1'b1;
                        end
                        default: begin
                        end
                    endcase
                end
                // Issue is applied last so a slot freed by commit this cycle
                // can be reallocated; it never collides with a live entry
                // because issue is blocked when full.
                if (issue_s) begin
                    busy_r[tail_r]      <= 1'b1;
                    ready_r[tail_r]     <= (issue_type == TYPE_EXIT);
                    type_r[tail_r]      <= issue_type;
                    rd_r[tail_r]        <= issue_rd;
                    pc_r[tail_r]        <= issue_pc;
                    pred_r[tail_r]      <= issue_pred_jump;
                    jump_addr_r[tail_r] <= issue_jump_addr;
                    jump_r[tail_r]      <= 1'b0;
                    tail_r              <= tail_r + ID_ONE;
                end
                case ({issue_s, commit_s})
                    2'b10:   count_r <= count_r + COUNT_ONE;
                    2'b01:   count_r <= count_r - COUNT_ONE;
                    default: count_r <= count_r;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_reorder_buffer.sv
// ---------------------------------------------------------------------------
// tb_reorder_buffer
//   Directed self-checking bench for reorder_buffer (ROB_WIDTH_BIT = 3).
//   Inputs change 1 ns after each rising edge; registered outputs are
//   checked at that point, combinational query outputs 1 ns after driving.
// ---------------------------------------------------------------------------
module tb_reorder_buffer;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        rdy_in;
    logic        issue_valid;
    logic [1:0]  issue_type;
    logic [4:0]  issue_rd;
    logic [31:0] issue_pc;
    logic        issue_pred_jump;
    logic [31:0] issue_jump_addr;
    logic [2:0]  tail_id;
    logic        rob_full;
    logic        wb_valid;
    logic [2:0]  wb_rob_id;
    logic [31:0] wb_value;
    logic        wb_jump;
    logic [2:0]  get_rob_id1;
    logic [2:0]  get_rob_id2;
    logic        rob_value1_ready;
    logic        rob_value2_ready;
    logic [31:0] rob_value1;
    logic [31:0] rob_value2;
    logic [4:0]  set_reg_id;
    logic [31:0] set_val;
    logic [2:0]  set_reg_on_rob_id;
    logic        commit_store;
    logic [2:0]  commit_rob_id;
    logic        rob_clear;
    logic [31:0] clear_pc;
    logic        halt;

    int checks_total  = 0;
    int checks_passed = 0;

    reorder_buffer #(.ROB_WIDTH_BIT(3)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
        .issue_valid(issue_valid), .issue_type(issue_type), .issue_rd(issue_rd),
        .issue_pc(issue_pc), .issue_pred_jump(issue_pred_jump), .issue_jump_addr(issue_jump_addr),
        .tail_id(tail_id), .rob_full(rob_full),
        .wb_valid(wb_valid), .wb_rob_id(wb_rob_id), .wb_value(wb_value), .wb_jump(wb_jump),
        .get_rob_id1(get_rob_id1), .get_rob_id2(get_rob_id2),
        .rob_value1_ready(rob_value1_ready), .rob_value2_ready(rob_value2_ready),
        .rob_value1(rob_value1), .rob_value2(rob_value2),
        .set_reg_id(set_reg_id), .set_val(set_val), .set_reg_on_rob_id(set_reg_on_rob_id),
        .commit_store(commit_store), .commit_rob_id(commit_rob_id),
        .rob_clear(rob_clear), .clear_pc(clear_pc), .halt(halt)
    );

    always #5 clk_in = ~clk_in;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks_total++;
        if (got === exp) begin
            checks_passed++;
        end else begin
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic do_reset();
        rst_in = 1'b1;
        issue_valid = 1'b0; wb_valid = 1'b0;
        step();
        rst_in = 1'b0;
    endtask

    task automatic set_issue(input logic [1:0] t, input logic [4:0] rd, input logic [31:0] pc,
                             input logic pj, input logic [31:0] ja);
        issue_valid = 1'b1; issue_type = t; issue_rd = rd;
        issue_pc = pc; issue_pred_jump = pj; issue_jump_addr = ja;
    endtask

    task automatic set_wb(input logic [2:0] id, input logic [31:0] v, input logic j);
        wb_valid = 1'b1; wb_rob_id = id; wb_value = v; wb_jump = j;
    endtask

    initial begin
        rdy_in = 1'b1; rst_in = 1'b1;
        issue_valid = 1'b0; issue_type = 2'd0; issue_rd = 5'd0; issue_pc = 32'd0;
        issue_pred_jump = 1'b0; issue_jump_addr = 32'd0;
        wb_valid = 1'b0; wb_rob_id = 3'd0; wb_value = 32'd0; wb_jump = 1'b0;
        get_rob_id1 = 3'd0; get_rob_id2 = 3'd0;
        step(); step();
        rst_in = 1'b0;

        // Reset state
        check("rst_tail_id", 32'(tail_id), 32'd0);
        check("rst_full", 32'(rob_full), 32'd0);
        check("rst_set_reg_id", 32'(set_reg_id), 32'd0);
        check("rst_set_val", set_val, 32'd0);
        check("rst_commit_store", 32'(commit_store), 32'd0);
        check("rst_rob_clear", 32'(rob_clear), 32'd0);
        check("rst_clear_pc", clear_pc, 32'd0);
        check("rst_halt", 32'(halt), 32'd0);

        // Basic REG issue, writeback, commit two cycles after writeback
        set_issue(2'd0, 5'd5, 32'h0, 1'b0, 32'h0);
        step();
        issue_valid = 1'b0;
        check("reg_tail_id", 32'(tail_id), 32'd1);
        set_wb(3'd0, 32'h1234, 1'b0);
        step();
        wb_valid = 1'b0;
        check("reg_no_early_commit", 32'(set_reg_id), 32'd0);
        step();
        check("reg_rd", 32'(set_reg_id), 32'd5);
        check("reg_val", set_val, 32'h1234);
        check("reg_rob_id", 32'(set_reg_on_rob_id), 32'd0);
        step();
        check("reg_pulse_end", 32'(set_reg_id), 32'd0);

        // Fill to full, wrap tail, ignore ninth issue, commit frees a slot
        do_reset();
        for (int i = 0; i < 8; i++) begin
            set_issue(2'd0, 5'(i + 1), 32'(i * 4), 1'b0, 32'h0);
            step();
            if (i == 6) begin
                check("fill7_tail", 32'(tail_id), 32'd7);
                check("fill7_not_full", 32'(rob_full), 32'd0);
            end
        end
        check("fill8_full", 32'(rob_full), 32'd1);
        check("fill8_tail_wrap", 32'(tail_id), 32'd0);
        set_issue(2'd0, 5'd20, 32'h40, 1'b0, 32'h0);
        step();
        issue_valid = 1'b0;
        check("ninth_ignored_tail", 32'(tail_id), 32'd0);
        check("ninth_still_full", 32'(rob_full), 32'd1);
        set_wb(3'd0, 32'hA0, 1'b0);
        step();
        wb_valid = 1'b0;
        step();
        check("full_commit_rd", 32'(set_reg_id), 32'd1);
        check("full_commit_val", set_val, 32'hA0);
        check("full_released", 32'(rob_full), 32'd0);

        // Query bypass while entries 1..7 are busy and unready
        get_rob_id1 = 3'd2; get_rob_id2 = 3'd3;
        set_wb(3'd2, 32'hBEEF, 1'b0);
        #1;
        check("q1_bypass_ready", 32'(rob_value1_ready), 32'd1);
        check("q1_bypass_value", rob_value1, 32'hBEEF);
        check("q2_unready", 32'(rob_value2_ready), 32'd0);
        step();
        wb_valid = 1'b0;
        #1;
        check("q1_stored_ready", 32'(rob_value1_ready), 32'd1);
        check("q1_stored_value", rob_value1, 32'hBEEF);

        // Mispredicted BRANCH (pred taken, actually not taken) with younger entries
        do_reset();
        set_issue(2'd2, 5'd0, 32'h100, 1'b1, 32'h200);
        step();
        set_issue(2'd0, 5'd7, 32'h104, 1'b0, 32'h0); step();
        set_issue(2'd0, 5'd8, 32'h108, 1'b0, 32'h0); step();
        set_issue(2'd0, 5'd9, 32'h10C, 1'b0, 32'h0); step();
        issue_valid = 1'b0;
        set_wb(3'd1, 32'h11, 1'b0);
        step();
        set_wb(3'd0, 32'h0, 1'b0);
        step();
        set_wb(3'd2, 32'h22, 1'b0);
        step();
        check("br_clear_pulse", 32'(rob_clear), 32'd1);
        check("br_clear_pc", clear_pc, 32'h104);
        check("br_no_link", 32'(set_reg_id), 32'd0);
        // Flush cycle: both must be ignored
        set_issue(2'd0, 5'd3, 32'h500, 1'b0, 32'h0);
        set_wb(3'd3, 32'h33, 1'b0);
        step();
        issue_valid = 1'b0; wb_valid = 1'b0;
        check("br_clear_end", 32'(rob_clear), 32'd0);
        check("br_tail_reset", 32'(tail_id), 32'd0);
        check("br_no_young_commit", 32'(set_reg_id), 32'd0);
        get_rob_id1 = 3'd1;
        #1;
        check("br_freed_ready", 32'(rob_value1_ready), 32'd0);
        step();
        check("br_still_idle", 32'(set_reg_id), 32'd0);

        // Mispredicted BRANCH the other way (pred not taken, actually taken) with link
        set_issue(2'd2, 5'd1, 32'h300, 1'b0, 32'h480);
        step();
        issue_valid = 1'b0;
        set_wb(3'd0, 32'h304, 1'b1);
        step();
        wb_valid = 1'b0;
        step();
        check("br2_clear", 32'(rob_clear), 32'd1);
        check("br2_clear_pc", clear_pc, 32'h480);
        check("br2_link_rd", 32'(set_reg_id), 32'd1);
        check("br2_link_val", set_val, 32'h304);
        step();
        check("br2_clear_end", 32'(rob_clear), 32'd0);

        // STORE then EXIT; halt is sticky and blocks later commits
        do_reset();
        set_issue(2'd1, 5'd0, 32'h600, 1'b0, 32'h0); step();
        set_issue(2'd3, 5'd0, 32'h604, 1'b0, 32'h0); step();
        issue_valid = 1'b0;
        set_wb(3'd0, 32'h0, 1'b0);
        step();
        wb_valid = 1'b0;
        step();
        check("st_commit_store", 32'(commit_store), 32'd1);
        check("st_commit_id", 32'(commit_rob_id), 32'd0);
        check("st_no_reg", 32'(set_reg_id), 32'd0);
        check("st_no_halt_yet", 32'(halt), 32'd0);
        step();
        check("exit_halt", 32'(halt), 32'd1);
        check("exit_store_end", 32'(commit_store), 32'd0);
        set_issue(2'd0, 5'd4, 32'h608, 1'b0, 32'h0); step();
        issue_valid = 1'b0;
        set_wb(3'd2, 32'h44, 1'b0);
        step();
        wb_valid = 1'b0;
        step(); step();
        check("halt_sticky", 32'(halt), 32'd1);
        check("halt_blocks_commit", 32'(set_reg_id), 32'd0);

        // Out-of-order writeback, in-order commit, rdy_in freeze
        do_reset();
        set_issue(2'd0, 5'd10, 32'h700, 1'b0, 32'h0); step();
        set_issue(2'd0, 5'd11, 32'h704, 1'b0, 32'h0); step();
        issue_valid = 1'b0;
        set_wb(3'd1, 32'h111, 1'b0);
        step();
        check("ooo_wait_head", 32'(set_reg_id), 32'd0);
        set_wb(3'd0, 32'h100, 1'b0);
        step();
        wb_valid = 1'b0;
        step();
        check("ooo_first_rd", 32'(set_reg_id), 32'd10);
        check("ooo_first_val", set_val, 32'h100);
        check("ooo_first_id", 32'(set_reg_on_rob_id), 32'd0);
        rdy_in = 1'b0;
        step(); step(); step();
        check("frz_rd", 32'(set_reg_id), 32'd10);
        check("frz_val", set_val, 32'h100);
        check("frz_tail", 32'(tail_id), 32'd2);
        rdy_in = 1'b1;
        step();
        check("ooo_second_rd", 32'(set_reg_id), 32'd11);
        check("ooo_second_val", set_val, 32'h111);
        check("ooo_second_id", 32'(set_reg_on_rob_id), 32'd1);
        step();
        check("ooo_idle", 32'(set_reg_id), 32'd0);

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
